a2d_rr_sched: RTL and testbench
===============================

Name: a2d_rr_sched

Overview:
Round-robin conversion scheduler for the ADC128S load-cell/battery A2D path. On each `nxt` strobe it runs one two-transaction SPI conversion on the next channel in sequence: left load cell, then right load cell, then battery. It drives the existing SPI master through the `wrt`/`done` handshake and holds the latest 12-bit result for each channel. These results feed steering-enable and battery-low logic in the digital core.

Parameters:
LFT_CHNL, 3'd0, A2D channel of the left load cell
RGHT_CHNL, 3'd4, A2D channel of the right load cell
BATT_CHNL, 3'd5, A2D channel of the battery divider
GAP_CYC, 4, idle clocks between the two SPI transactions of one conversion (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
nxt  in  1  single-cycle request to start the next conversion
done  in  1  SPI master transaction complete (1-cycle pulse)
rd_data  in  16  SPI master received word, valid when `done`=1
wrt  out  1  single-cycle start pulse to SPI master
cmd  out  16  SPI command word
lft_ld  out  12  latest left load-cell result
rght_ld  out  12  latest right load-cell result
batt  out  12  latest battery result
smpl_vld  out  1  1-cycle pulse when a result register updates
chnl_idx  out  2  channel currently/next scheduled: 0=lft, 1=rght, 2=batt
busy  out  1  high from accepted `nxt` until the result is stored

Behaviour:
- Reset (async, `rst`=1):
  - state=IDLE; wrt=0; cmd=16'h0000; busy=0; smpl_vld=0.
  - lft_ld, rght_ld and batt all =12'h000; chnl_idx=0; gap counter=0.
  - Reset mid-conversion aborts immediately. No partial result is stored. The next conversion starts at lft.
- Command encoding: `cmd = {2'b00, chnl[2:0], 11'h000}`, where `chnl` is the parameter selected by chnl_idx. `cmd` is registered and held stable from the `wrt` cycle until the state returns to IDLE.
- States: IDLE, CMD, GAP, READ, STORE.
- IDLE: on `nxt`=1, load `cmd`, pulse `wrt` for exactly 1 cycle, set `busy`=1, go to CMD.
- CMD: wait for `done`. `rd_data` is discarded because the ADC returns the previous conversion. On `done`, clear the gap counter and go to GAP.
- GAP: count GAP_CYC clocks. On the last count, pulse `wrt` (same `cmd`) and go to READ.
- READ: wait for `done`. On `done`, capture `rd_data[11:0]` into the register selected by chnl_idx in that same edge, then go to STORE.
- STORE (1 cycle):
  - Assert `smpl_vld`=1 and drop `busy`.
  - Advance chnl_idx 0→1→2→0; the wrap from 2 to 0 is required and 3 is never reached.
  - Return to IDLE.
- Latency: from the `nxt` cycle to `smpl_vld`, latency = 1 + T_spi + GAP_CYC + T_spi + 1 clocks, where T_spi is the master's `wrt`→`done` time.
- `nxt` while `busy`=1 or in STORE is ignored, not queued.
- `nxt` on the cycle after STORE (IDLE) is accepted normally.
- `done` in IDLE, GAP or STORE is ignored. It causes no state change and no register write.
- `rd_data[15:12]` is ignored.
- Result registers update only in READ on `done`. Non-selected registers hold their value.
- `wrt` is never asserted while waiting for `done`. At most 2 `wrt` pulses occur per conversion.

Test Plan:
- Reset check: assert `rst`, then release. Required: all outputs zero, chnl_idx=0, no `wrt` for 100 clocks without `nxt`.
- Round robin with the ADC128S model set to lft=12'h110, rght=12'h100, batt=12'hC00; issue 3 `nxt` strobes, each after the previous `smpl_vld`. Required:
  - `cmd` sequence 16'h0000, 16'h2000, 16'h2800.
  - lft_ld=12'h110, rght_ld=12'h100, batt=12'hC00.
  - Exactly 3 `smpl_vld` pulses.
  - A 4th `nxt` re-reads lft with cmd=16'h0000.
- Gap/handshake: with GAP_CYC=4, measure `done`(1st) to `wrt`(2nd). Required: exactly 4 clocks, and exactly 2 `wrt` pulses per conversion.
- Busy collision: pulse `nxt` in CMD, GAP and READ. Required: no extra `wrt`, chnl_idx advances by 1 only, a single `smpl_vld`.
- Reset mid-READ: assert `rst` while in READ with the model at rght=12'h3FF. Required: rght_ld stays 12'h000, `busy`=0; the next `nxt` produces cmd=16'h0000.
- Stray `done`: force a `done` pulse in IDLE with rd_data=16'h0ABC. Required: no state change, all result registers unchanged, no `smpl_vld`.

Source files
------------

// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched
//   Round-robin A2D conversion scheduler for the ADC128S load-cell/battery path.
//   Each accepted `nxt` runs one two-transaction SPI conversion on the next
//   channel (left load cell -> right load cell -> battery -> left ...).  The
//   first transaction only addresses the channel (the ADC returns the result
//   of the previously addressed channel, which is discarded).  The second
//   transaction, issued GAP_CYC clocks after the first completes, returns the
//   wanted sample.
//
// Handshake with the SPI master: `wrt` is a one-cycle start request.  The
// master answers with a one-cycle `done`, and `rd_data` is valid only in that
// cycle.  `done` is acted on only while a transaction is outstanding (CMD or
// READ).  `wrt` is never raised again until that `done` has been seen.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   nxt       request to start the next conversion (ignored unless idle)
//   done      SPI master transaction complete pulse
//   rd_data   SPI master received word, low 12 bits carry the sample
//   wrt       start pulse to SPI master
//   cmd       SPI command word {2'b00, chnl[2:0], 11'h000}
//   lft_ld    latest left load-cell result
//   rght_ld   latest right load-cell result
//   batt      latest battery result
//   smpl_vld  one-cycle pulse in the cycle after a result register updates
//   chnl_idx  channel currently/next scheduled (0=lft, 1=rght, 2=batt)
//   busy      high from the accepted `nxt` until the result is stored
module a2d_rr_sched #(
  parameter logic [2:0]  LFT_CHNL  = 3'd0,
  parameter logic [2:0]  RGHT_CHNL = 3'd4,
  parameter logic [2:0]  BATT_CHNL = 3'd5,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        smpl_vld,
  output logic [1:0]  chnl_idx,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    STORE = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] gap_cnt;
  logic       wrt_first;   // registered start pulse of the addressing transaction
  logic       gap_last;    // last idle clock of the gap: start the read transaction
  logic [2:0] chnl_sel;
  logic       start;

  // The upper nibble of the received word carries no sample information.
  logic       unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    case (chnl_idx)
      2'd0:    chnl_sel = LFT_CHNL;
      2'd1:    chnl_sel = RGHT_CHNL;
      default: chnl_sel = BATT_CHNL;
    endcase
  end

  assign start = (state == IDLE) && nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and decoded outputs
  always_comb begin
    state_nxt = state;
    gap_last  = 1'b0;
    wrt       = 1'b0;
    busy      = 1'b0;
    smpl_vld  = 1'b0;
    case (state)
      IDLE: begin
        if (nxt) state_nxt = CMD;
      end
      CMD: begin
        busy = 1'b1;
        if (done) state_nxt = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          gap_last  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (done) state_nxt = STORE;
      end
      STORE: begin
        smpl_vld  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The first pulse comes from a flop so it lands in the first CMD cycle;
    // the second is decoded so it falls exactly GAP_CYC clocks after `done`.
    wrt = wrt_first | gap_last;
  end

  // Datapath: command, gap counter, results, channel pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrt_first <= 1'b0;
      cmd       <= 16'h0000;
      gap_cnt   <= 4'd0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      batt      <= 12'h000;
      chnl_idx  <= 2'd0;
    end else begin
      wrt_first <= start;
      if (start) cmd <= {2'b00, chnl_sel, 11'h000};

      if ((state == CMD) && done) gap_cnt <= 4'd0;
      else if (state == GAP)      gap_cnt <= gap_cnt + 4'd1;

      if ((state == READ) && done) begin
        case (chnl_idx)
          2'd0:    lft_ld  <= rd_data[11:0];
          2'd1:    rght_ld <= rd_data[11:0];
          default: batt    <= rd_data[11:0];
        endcase
      end

      if (state == STORE) chnl_idx <= (chnl_idx == 2'd2) ? 2'd0 : chnl_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb_a2d_rr_sched
//   Bench for a2d_rr_sched.  An ADC128S/SPI master model answers `wrt` after a
//   per-conversion latency and returns the sample of the channel addressed by
//   the previous transaction.  Expected results come from a channel-level
//   model: conversion k on pointer p must read adc_val[channel(p)] into the
//   result slot p and issue the command for channel(p) twice.
module tb_a2d_rr_sched;

  localparam int GAP = 4;
  localparam logic [2:0] CHNL_MAP [3] = '{3'd0, 3'd4, 3'd5};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        nxt;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        smpl_vld;
  logic [1:0]  chnl_idx;
  logic        busy;

  logic        model_done;
  logic        stray_done;
  logic [15:0] model_data;
  logic [15:0] stray_data;

  assign done    = model_done | stray_done;
  assign rd_data = stray_done ? stray_data : model_data;

  a2d_rr_sched #(.GAP_CYC(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .nxt      (nxt),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .smpl_vld (smpl_vld),
    .chnl_idx (chnl_idx),
    .busy     (busy)
  );

  // ---------------- ADC128S + SPI master model ----------------
  logic [11:0] adc_val [8];
  int          t_spi;
  int          spi_cnt;
  logic [2:0]  spi_addr;
  logic [2:0]  adc_prev;
  logic [3:0]  junk;

  initial begin
    model_done = 1'b0;
    model_data = 16'h0000;
    spi_cnt    = 0;
    spi_addr   = 3'd0;
    adc_prev   = 3'd0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (rst) begin
        spi_cnt = 0;
      end else begin
        if (spi_cnt > 0) begin
          spi_cnt--;
          if (spi_cnt == 0) begin
            junk       = 4'($urandom_range(0, 15));
            model_data = {junk, adc_val[adc_prev]};
            adc_prev   = spi_addr;
            model_done = 1'b1;
          end
        end
        if (wrt) begin
          spi_cnt  = t_spi;
          spi_addr = cmd[13:11];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  logic [11:0] exp_res [3];
  int          exp_idx;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_lft"},  {20'h0, lft_ld},   {20'h0, exp_res[0]});
    chk({tag, "_rght"}, {20'h0, rght_ld},  {20'h0, exp_res[1]});
    chk({tag, "_batt"}, {20'h0, batt},     {20'h0, exp_res[2]});
    chk({tag, "_idx"},  {30'h0, chnl_idx}, 32'(exp_idx));
  endtask

  task automatic model_reset;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_res[i] = 12'h000;
    exp_idx = 0;
  endtask

  // One full conversion; with `collide` set, `nxt` is held high from the
  // first CMD cycle through STORE.
  task automatic run_conv(input int t, input bit collide);
    int start_c, d1, w2, sv, nw, nsv, k;
    logic [15:0] ec;
    t_spi = t;
    ec = {2'b00, CHNL_MAP[exp_idx], 11'h000};
    exp_q.delete();
    exp_q.push_back(ec);
    exp_q.push_back(ec);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    nxt = 1'b1;
    start_c = cyc;
    tick;
    nxt = 1'b0;
    d1 = -1; w2 = -1; sv = -1; nw = 0; nsv = 0; k = 0;
    while (sv < 0 && k < 400) begin
      if (wrt) begin
        nw++;
        if (exp_q.size() > 0) chk("cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
        else chk("extra_wrt", 32'(nw), 32'd2);
        if (nw == 2) w2 = cyc;
      end
      if (done && nw == 1 && d1 < 0) d1 = cyc;
      if (smpl_vld) begin
        nsv++;
        sv = cyc;
      end
      nxt = collide;
      tick;
      k++;
    end
    nxt = 1'b0;
    chk("conv_timeout", {31'h0, sv >= 0}, 32'h1);
    exp_res[exp_idx] = adc_val[CHNL_MAP[exp_idx]];
    exp_idx = (exp_idx + 1) % 3;
    for (int i = 0; i < 6; i++) begin
      if (wrt) nw++;
      if (smpl_vld) nsv++;
      tick;
    end
    chk("wrt_count", 32'(nw), 32'd2);
    chk("smpl_vld_count", 32'(nsv), 32'd1);
    chk("gap_done_to_wrt", 32'(w2 - d1), 32'(GAP));
    chk("latency", 32'(sv - start_c), 32'(2 + 2 * t + GAP));
    chk("cmd_q_empty", 32'(exp_q.size()), 32'd0);
    chk_regs("conv");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int nw, k;
    logic [11:0] snap_l, snap_r, snap_b;
    rst = 1'b1;
    nxt = 1'b0;
    stray_done = 1'b0;
    stray_data = 16'h0000;
    t_spi = 3;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    model_reset();
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst_wrt",      {31'h0, wrt},      32'h0);
    chk("rst_cmd",      {16'h0, cmd},      32'h0);
    chk("rst_busy",     {31'h0, busy},     32'h0);
    chk("rst_smpl_vld", {31'h0, smpl_vld}, 32'h0);
    chk_regs("rst");
    nw = 0;
    for (int i = 0; i < 100; i++) begin
      if (wrt) nw++;
      tick;
    end
    chk("idle_no_wrt", 32'(nw), 32'd0);

    // Round robin with fixed samples
    adc_val[0] = 12'h110;
    adc_val[4] = 12'h100;
    adc_val[5] = 12'hC00;
    for (int i = 0; i < 3; i++) run_conv($urandom_range(1, 6), 1'b0);
    chk("rr_lft",  {20'h0, lft_ld},  32'h110);
    chk("rr_rght", {20'h0, rght_ld}, 32'h100);
    chk("rr_batt", {20'h0, batt},    32'hC00);
    adc_val[0] = 12'h5A5;
    run_conv($urandom_range(1, 6), 1'b0);
    chk("rr_lft_reread", {20'h0, lft_ld}, 32'h5A5);

    // Busy collision
    run_conv($urandom_range(2, 6), 1'b1);

    // Random samples, latencies and collisions
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom_range(0, 4095));
      run_conv($urandom_range(1, 8), 1'($urandom_range(0, 1)));
    end

    // Reset during READ of the right channel
    k = 0;
    while (exp_idx != 1 && k < 3) begin
      run_conv(2, 1'b0);
      k++;
    end
    chk("pre_rst_idx", {30'h0, chnl_idx}, 32'h1);
    adc_val[4] = 12'h3FF;
    t_spi = 8;
    nxt = 1'b1;
    tick;
    nxt = 1'b0;
    nw = 0;
    k = 0;
    while (nw < 2 && k < 100) begin
      if (wrt) nw++;
      if (nw < 2) tick;
      k++;
    end
    chk("mid_read_reach", 32'(nw), 32'd2);
    tick;
    chk("mid_read_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick;
    model_reset();
    chk("mid_rst_busy", {31'h0, busy},     32'h0);
    chk("mid_rst_sv",   {31'h0, smpl_vld}, 32'h0);
    chk("mid_rst_rght", {20'h0, rght_ld},  32'h000);
    tick;
    rst = 1'b0;
    repeat (2) tick;
    chk_regs("after_mid_rst");
    run_conv(3, 1'b0);

    // Stray done while idle
    snap_l = lft_ld;
    snap_r = rght_ld;
    snap_b = batt;
    stray_data = 16'h0ABC;
    stray_done = 1'b1;
    tick;
    stray_done = 1'b0;
    nw = 0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (wrt) nw++;
      if (smpl_vld || busy) k++;
      tick;
    end
    chk("stray_no_wrt",   32'(nw), 32'd0);
    chk("stray_no_state", 32'(k),  32'd0);
    chk("stray_lft",  {20'h0, lft_ld},  {20'h0, snap_l});
    chk("stray_rght", {20'h0, rght_ld}, {20'h0, snap_r});
    chk("stray_batt", {20'h0, batt},    {20'h0, snap_b});
    chk_regs("stray");
    run_conv(4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
